// File: rtl/id_register_file.sv
// Two-read / one-write register file with register 0 hardwired to zero, plus a
// ready/valid register dump engine. Optional macro REGFILE_WB_BYPASS_EN forwards writeback data to reads.
module id_register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_WB_reg_write,
  input  logic [NB_REG-1:0]  i_WB_selected_reg,
  input  logic [NB_DATA-1:0] i_WB_selected_data,
  input  logic [NB_REG-1:0]  i_ID_rs,
  input  logic [NB_REG-1:0]  i_ID_rt,
  output logic [NB_DATA-1:0] o_ID_rs_data,
  output logic [NB_DATA-1:0] o_ID_rt_data,
  input  logic               i_dump_start,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic [NB_REG-1:0]  o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  localparam int N_REGS = 2 ** NB_REG;
  localparam logic [NB_REG-1:0] LAST_IDX = {NB_REG{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } dump_state_e;

  logic [NB_DATA-1:0] regs_q [N_REGS];
  logic               wr_en;

  dump_state_e        state_q, state_d;
  logic [NB_REG-1:0]  idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Register 0 is never written, so its reset value of zero is permanent.
  assign wr_en = i_WB_reg_write && (i_WB_selected_reg != '0);

  // NOTE: this array is reset on purpose -- an asynchronous clear of every entry is
  // part of the block's contract, which forces flops rather than a RAM macro.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[i_WB_selected_reg] <= i_WB_selected_data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    o_ID_rs_data = regs_q[i_ID_rs];
    o_ID_rt_data = regs_q[i_ID_rt];
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_en && (i_ID_rs == i_WB_selected_reg)) o_ID_rs_data = i_WB_selected_data;
    if (wr_en && (i_ID_rt == i_WB_selected_reg)) o_ID_rt_data = i_WB_selected_data;
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (i_dump_start) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (i_dump_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    // Status flags are decoded from the next state so they come straight off flops.
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Dump data reads stored contents only; the bypass never applies here.
  assign o_dump_valid = valid_q;
  assign o_dump_addr  = valid_q ? idx_q : '0;
  assign o_dump_data  = valid_q ? regs_q[idx_q] : '0;
  assign o_dump_busy  = busy_q;
  assign o_dump_done  = done_q;

endmodule

// File: tb/tb_id_register_file.sv
// Randomized bench for id_register_file against an array model of the register file
// and a beat-counting model of the dump sequence.
module tb_id_register_file;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NR      = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               wr;
  logic [NB_REG-1:0]  wa;
  logic [NB_DATA-1:0] wd;
  logic [NB_REG-1:0]  rs, rt;
  logic [NB_DATA-1:0] rs_data, rt_data;
  logic               start, ready;
  logic               dump_valid, dump_busy, dump_done;
  logic [NB_REG-1:0]  dump_addr;
  logic [NB_DATA-1:0] dump_data;

  logic [NB_DATA-1:0] model [NR];
  int n_checks = 0;
  int n_fails  = 0;

  id_register_file #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_WB_reg_write     (wr),
    .i_WB_selected_reg  (wa),
    .i_WB_selected_data (wd),
    .i_ID_rs            (rs),
    .i_ID_rt            (rt),
    .o_ID_rs_data       (rs_data),
    .o_ID_rt_data       (rt_data),
    .i_dump_start       (start),
    .o_dump_valid       (dump_valid),
    .i_dump_ready       (ready),
    .o_dump_addr        (dump_addr),
    .o_dump_data        (dump_data),
    .o_dump_busy        (dump_busy),
    .o_dump_done        (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected read: stored value, or this cycle's write data when forwarding is built in.
  function automatic logic [NB_DATA-1:0] exp_read(input logic [NB_REG-1:0] idx);
    if (BYP && wr && wa != 0 && wa == idx) return wd;
    return model[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n && wr && wa != 0) model[wa] = wd;
    @(negedge clk);
  endtask

  task automatic run_dump(input bit rnd_ready, input bit do_writes, input bit restart,
                          input int abort_at);
    int beats = 0;
    int dones = 0;
    bit prev_stall = 1'b0;
    bit prev_hit = 1'b0;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    logic [NB_REG-1:0]  prev_addr = '0;
    logic [NB_DATA-1:0] prev_data = '0;
    wr = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wr    = do_writes ? 1'($urandom_range(0, 1)) : 1'b0;
      wa    = 5'($urandom);
      wd    = $urandom;
      start = restart ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (abort_at >= 0 && beats == abort_at && dump_valid) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", dump_valid, 0);
        check("abort_busy",  dump_busy,  0);
        check("abort_done",  dump_done,  0);
        check("abort_addr",  dump_addr,  0);
        check("abort_data",  dump_data,  0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        aborted = 1'b1;
        finished = 1'b1;
      end else begin
        #1;
        if (dump_done) begin
          dones++;
          check("done_busy",  dump_busy,  1);
          check("done_valid", dump_valid, 0);
        end
        if (dump_valid) begin
          check("beat_addr", dump_addr, 64'(beats));
          check("beat_data", dump_data, model[dump_addr]);
          check("beat_busy", dump_busy, 1);
          if (prev_stall) begin
            check("hold_addr", dump_addr, prev_addr);
            if (!prev_hit) check("hold_data", dump_data, prev_data);
          end
          prev_stall = !ready;
          prev_addr  = dump_addr;
          prev_data  = dump_data;
          prev_hit   = wr && (wa == dump_addr);
          if (ready) beats++;
        end else begin
          prev_stall = 1'b0;
        end
        tick();
        if (dones > 0) finished = 1'b1;
      end
    end
    start = 1'b0;
    wr = 1'b0;
    if (aborted) begin
      for (int i = 0; i < 2; i++) begin
        tick();
        check("rst_hold_done", dump_done, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("post_rst_busy", dump_busy, 0);
        check("post_rst_done", dump_done, 0);
      end
      for (int i = 0; i < NR; i++) begin
        rs = 5'(i);
        rt = 5'(NR - 1 - i);
        #1;
        check("post_rst_rs", rs_data, 0);
        check("post_rst_rt", rt_data, 0);
      end
    end else begin
      check("dump_beats", 64'(beats), 64'(NR));
      check("dump_dones", 64'(dones), 1);
      check("after_done_busy", dump_busy, 0);
      tick();
      check("no_requeue_busy",  dump_busy,  0);
      check("no_requeue_valid", dump_valid, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr = 1'b0; wa = '0; wd = '0;
    rs = 5'd5; rt = 5'd31;
    start = 1'b0; ready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #3;
    check("reset_rs",    rs_data,    0);
    check("reset_rt",    rt_data,    0);
    check("reset_busy",  dump_busy,  0);
    check("reset_valid", dump_valid, 0);
    check("reset_done",  dump_done,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wr = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
    tick();
    wr = 1'b0; rs = 5'd7;
    #1 check("read_r7", rs_data, 32'hDEADBEEF);
    wr = 1'b1; wa = 5'd0; wd = 32'h12345678; rs = 5'd0;
    #1 check("r0_during_write", rs_data, 0);
    tick();
    wr = 1'b0;
    #1 check("r0_after_write", rs_data, 0);

    wr = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; rt = 5'd9;
    #1 check("same_cycle_r9", rt_data, BYP ? 32'hA5A5A5A5 : 32'h0);
    tick();
    wr = 1'b0;
    #1 check("next_cycle_r9", rt_data, 32'hA5A5A5A5);

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      wa = 5'($urandom);
      wd = $urandom;
      rs = 5'($urandom);
      rt = (n % 4 == 0) ? wa : 5'($urandom);
      #1;
      check("rand_rs", rs_data, exp_read(rs));
      check("rand_rt", rt_data, exp_read(rt));
      tick();
    end
    wr = 1'b0;

    run_dump(1'b0, 1'b0, 1'b0, -1);
    run_dump(1'b1, 1'b1, 1'b1, -1);
    run_dump(1'b1, 1'b1, 1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
